// File: rtl/button_pkg.sv
// Shared state encoding and default timing for the push-button debouncer.
package button_pkg;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_PRESS_CHK = 2'd1,
        S_HELD      = 2'd2,
        S_REL_CHK   = 2'd3
    } btn_state_t;

    localparam int unsigned DEBOUNCE_10MS_25MHZ = 250_000;
    localparam int unsigned HOLD_1S_25MHZ       = 25_000_000;

endpackage

// File: rtl/sync_bit.sv
// Multi-flop synchronizer for a single asynchronous bit; clears to 0 on reset.
module sync_bit #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/button_event_debouncer.sv
// Debounces one raw push-button into a clean level plus press, release and long-hold pulses.
//   state       | meaning
//   S_IDLE      | released and stable, level 0
//   S_PRESS_CHK | candidate press, waiting for DEBOUNCE_CYCLES of stable high
//   S_HELD      | accepted press, level 1, hold timer running
//   S_REL_CHK   | candidate release, level still 1, hold timer frozen
module button_event_debouncer
    import button_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_10MS_25MHZ,
    parameter int unsigned LONG_CYCLES     = HOLD_1S_25MHZ
) (
    input  logic i_Clk,
    input  logic i_Rst,
    input  logic i_Switch,
    output logic o_Level,
    output logic o_Press,
    output logic o_Release,
    output logic o_Long
);

    localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned HOLD_W = $clog2(LONG_CYCLES);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_FIRE = HOLD_W'(LONG_CYCLES - 2);

    logic              sw_s;
    btn_state_t        state;
    logic [DB_W-1:0]   db_cnt;
    logic [HOLD_W-1:0] hold_cnt;

    sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (i_Clk),
        .rst (i_Rst),
        .d   (i_Switch),
        .q   (sw_s)
    );

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state     <= S_IDLE;
            db_cnt    <= '0;
            hold_cnt  <= '0;
            o_Level   <= 1'b0;
            o_Press   <= 1'b0;
            o_Release <= 1'b0;
            o_Long    <= 1'b0;
        end else begin
            o_Press   <= 1'b0;
            o_Release <= 1'b0;
            o_Long    <= 1'b0;
            case (state)
                S_IDLE: begin
                    o_Level <= 1'b0;
                    if (sw_s) begin
                        state  <= S_PRESS_CHK;
                        db_cnt <= '0;
                    end
                end
                S_PRESS_CHK: begin
                    if (!sw_s) begin
                        state <= S_IDLE;
                    end else if (db_cnt == DB_LAST) begin
                        state    <= S_HELD;
                        hold_cnt <= '0;
                        o_Level  <= 1'b1;
                        o_Press  <= 1'b1;
                    end else begin
                        db_cnt <= db_cnt + DB_W'(1);
                    end
                end
                S_HELD: begin
                    // Saturation makes the HOLD_FIRE crossing happen once per press.
                    if (hold_cnt != HOLD_LAST) begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                    if (hold_cnt == HOLD_FIRE) begin
                        o_Long <= 1'b1;
                    end
                    if (!sw_s) begin
                        state  <= S_REL_CHK;
                        db_cnt <= '0;
                    end
                end
                S_REL_CHK: begin
                    if (sw_s) begin
                        state <= S_HELD;
                    end else if (db_cnt == DB_LAST) begin
                        state     <= S_IDLE;
                        o_Level   <= 1'b0;
                        o_Release <= 1'b1;
                    end else begin
                        db_cnt <= db_cnt + DB_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_button_event_debouncer.sv
// Directed bench for button_event_debouncer with short debounce/hold timing.
module tb_button_event_debouncer;

    logic clk = 1'b0;
    logic i_Rst = 1'b1;
    logic i_Switch = 1'b0;
    logic o_Level, o_Press, o_Release, o_Long;

    always #5 clk = ~clk;

    button_event_debouncer #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4),
        .LONG_CYCLES     (16)
    ) dut (
        .i_Clk     (clk),
        .i_Rst     (i_Rst),
        .i_Switch  (i_Switch),
        .o_Level   (o_Level),
        .o_Press   (o_Press),
        .o_Release (o_Release),
        .o_Long    (o_Long)
    );

    typedef struct {
        logic       rst;
        logic       sw;
        logic [3:0] exp;   // {level, press, release, long}
    } vec_t;

    vec_t vecs[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Per-edge event recorder, indexed from the last clear_rec.
    int t, p_cnt, p_at, r_cnt, r_at, l_cnt, l_at, clash, lvl_bad;

    function automatic void add(input logic rst, input logic sw, input logic [3:0] exp, input int n);
        vec_t v;
        v.rst = rst;
        v.sw  = sw;
        v.exp = exp;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_rec();
        t = 0; p_cnt = 0; p_at = -1; r_cnt = 0; r_at = -1;
        l_cnt = 0; l_at = -1; clash = 0; lvl_bad = 0;
    endtask

    task automatic step(input logic rst, input logic sw);
        @(negedge clk);
        i_Rst    = rst;
        i_Switch = sw;
        @(posedge clk);
        #1;
        t++;
        if (o_Press)   begin p_cnt++; p_at = t; end
        if (o_Release) begin r_cnt++; r_at = t; end
        if (o_Long)    begin l_cnt++; l_at = t; end
        if (o_Long && o_Release) clash++;
        if ((o_Press && !o_Level) || (o_Release && o_Level)) lvl_bad++;
    endtask

    task automatic seg(input logic rst, input logic sw, input int n);
        for (int i = 0; i < n; i++) step(rst, sw);
    endtask

    initial begin
        // Reset, then test 1: clean press for 10 cycles and release.
        add(1'b1, 1'b0, 4'b0000, 2);
        add(1'b0, 1'b1, 4'b0000, 6);
        add(1'b0, 1'b1, 4'b1100, 1);
        add(1'b0, 1'b1, 4'b1000, 3);
        add(1'b0, 1'b0, 4'b1000, 6);
        add(1'b0, 1'b0, 4'b0010, 1);
        add(1'b0, 1'b0, 4'b0000, 3);
        // Test 2: bounce 1,1,0,1,1 then 0 -- never accepted.
        add(1'b0, 1'b1, 4'b0000, 2);
        add(1'b0, 1'b0, 4'b0000, 1);
        add(1'b0, 1'b1, 4'b0000, 2);
        add(1'b0, 1'b0, 4'b0000, 10);

        clear_rec();
        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].sw);
            chk($sformatf("vec%0d", i), int'({o_Level, o_Press, o_Release, o_Long}), int'(vecs[i].exp));
        end

        // Test 3: 30-cycle hold produces one long pulse 15 cycles after press.
        clear_rec();
        seg(1'b0, 1'b1, 30);
        seg(1'b0, 1'b0, 12);
        chk("t3_press_cnt", p_cnt, 1);
        chk("t3_press_at",  p_at,  7);
        chk("t3_long_cnt",  l_cnt, 1);
        chk("t3_long_at",   l_at,  22);
        chk("t3_rel_cnt",   r_cnt, 1);
        chk("t3_rel_at",    r_at,  37);
        chk("t3_level_end", int'(o_Level), 0);

        // Test 4: 2-cycle release bounce while held delays the long pulse by 2.
        clear_rec();
        seg(1'b0, 1'b1, 10);
        seg(1'b0, 1'b0, 2);
        seg(1'b0, 1'b1, 28);
        seg(1'b0, 1'b0, 12);
        chk("t4_press_cnt", p_cnt, 1);
        chk("t4_long_cnt",  l_cnt, 1);
        chk("t4_long_at",   l_at,  24);
        chk("t4_rel_cnt",   r_cnt, 1);
        chk("t4_rel_at",    r_at,  47);

        // Test 5: one-cycle reset while held and still pressed.
        clear_rec();
        seg(1'b0, 1'b1, 12);
        chk("t5_level_held", int'(o_Level), 1);
        step(1'b1, 1'b1);
        chk("t5_outs_after_rst", int'({o_Level, o_Press, o_Release, o_Long}), 0);
        clear_rec();
        seg(1'b0, 1'b1, 12);
        seg(1'b0, 1'b0, 10);
        chk("t5_press_cnt", p_cnt, 1);
        chk("t5_press_at",  p_at,  7);
        chk("t5_rel_cnt",   r_cnt, 1);
        chk("t5_rel_at",    r_at,  19);

        // Test 6: switch held through reset is reported as a fresh press.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1);
            chk($sformatf("t6_rst_outs%0d", i), int'({o_Level, o_Press, o_Release, o_Long}), 0);
        end
        clear_rec();
        seg(1'b0, 1'b1, 12);
        chk("t6_press_cnt", p_cnt, 1);
        chk("t6_press_at",  p_at,  7);
        chk("t6_rel_none",  r_cnt, 0);
        seg(1'b0, 1'b0, 10);
        chk("t6_rel_cnt",   r_cnt, 1);
        chk("t6_clash",     clash, 0);
        chk("t6_lvl_pulse", lvl_bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
